// File: rtl/seq_pkg.sv
// Shared definitions for the LED/tone sequence player: state encoding,
// colour decode and default timing constants.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_ON     = 3'd3,
      S_GAP    = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   localparam int ON_TICKS_DEF     = 8;
   localparam int GAP_TICKS_DEF    = 4;
   localparam int MIN_ON_TICKS_DEF = 2;
   localparam int LEN_MAX          = 32;

   // Colour code n lights lamp n.
   function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
      return 4'b0001 << colour;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating up-counter of TICK pulses. o_expired flags the TICK that makes
// the count reach i_target; the owner clears the count on every phase change.
module dwell_timer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clear,
   input  logic       i_tick,
   input  logic [7:0] i_target,
   output logic       o_expired
);

   logic [7:0] r_count;
   logic       w_at_max;

   assign w_at_max  = (r_count == 8'hFF);
   assign o_expired = i_tick && !w_at_max && ((r_count + 8'd1) == i_target);

   // Count TICKs, holding at 255 instead of wrapping.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_count <= 8'd0;
      else if (i_clear)
         r_count <= 8'd0;
      else if (i_tick && !w_at_max)
         r_count <= r_count + 8'd1;
   end

endmodule

// File: rtl/seq_player.sv
// Plays a stored colour sequence on one-hot lamps with a matching tone.
// Each entry is fetched from a synchronous pattern memory, lit for an
// on-time, then followed by a dark gap.
// Build option: define SEQ_SPEEDUP_EN to shorten the on-time by one TICK for
// every four entries played, floored at MIN_ON_TICKS.
//
// state  | meaning
// IDLE   | waiting for START
// FETCH  | read address presented for current entry
// LATCH  | memory data captured as the lamp colour
// ON     | lamp and tone active, counting on-time TICKs
// GAP    | dark, counting gap TICKs
// FINISH | one-cycle DONE, then back to IDLE
module seq_player
   import seq_pkg::*;
#(
   parameter int ON_TICKS     = ON_TICKS_DEF,
   parameter int GAP_TICKS    = GAP_TICKS_DEF,
   parameter int MIN_ON_TICKS = MIN_ON_TICKS_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic [5:0] i_len,
   input  logic       i_tick,
   output logic [4:0] o_rd_addr,
   input  logic [1:0] i_rd_data,
   output logic [3:0] o_led,
   output logic       o_tone_en,
   output logic [1:0] o_tone_sel,
   output logic       o_busy,
   output logic       o_done
);

   // Keeps the base on-time from ever sitting below the speed-up floor.
   localparam int ON_EFF = (ON_TICKS < MIN_ON_TICKS) ? MIN_ON_TICKS : ON_TICKS;

   state_t     r_state;
   logic [4:0] r_index;
   logic [5:0] r_len;
   logic [1:0] r_colour;
   logic [4:0] r_rd_addr;
   logic [3:0] r_led;
   logic       r_tone_en;
   logic       r_busy;
   logic       r_done;

   logic [5:0] w_len_clamped;
   logic       w_last;
   logic       w_clear;
   logic       w_expired;
   logic [7:0] w_target;
   logic [7:0] w_on_time;

   assign w_len_clamped = (i_len > 6'(LEN_MAX)) ? 6'(LEN_MAX) : i_len;
   assign w_last        = ({1'b0, r_index} == (r_len - 6'd1));

`ifdef SEQ_SPEEDUP_EN
   int w_on_int;

   // On-time shrinks by one TICK per group of four entries, down to the floor.
   always_comb begin
      w_on_int = ON_EFF - int'(r_index[4:2]);
      if (w_on_int < MIN_ON_TICKS)
         w_on_int = MIN_ON_TICKS;
      w_on_time = 8'(w_on_int);
   end
`else
   assign w_on_time = 8'(ON_EFF);
`endif

   // The timer only runs in ON and GAP and restarts at every phase boundary,
   // so TICKs in FETCH, LATCH and FINISH are never counted.
   assign w_clear  = !((r_state == S_ON) || (r_state == S_GAP)) || w_expired || i_abort;
   assign w_target = (r_state == S_GAP) ? 8'(GAP_TICKS) : w_on_time;

   dwell_timer u_dwell_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_clear),
      .i_tick    (i_tick),
      .i_target  (w_target),
      .o_expired (w_expired)
   );

   // Sequencer with registered lamp, tone and handshake outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_index   <= 5'd0;
         r_len     <= 6'd0;
         r_colour  <= 2'd0;
         r_rd_addr <= 5'd0;
         r_led     <= 4'd0;
         r_tone_en <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else if (i_abort) begin
         r_state   <= S_IDLE;
         r_led     <= 4'd0;
         r_tone_en <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_len     <= w_len_clamped;
                  r_index   <= 5'd0;
                  r_rd_addr <= 5'd0;
                  if (w_len_clamped == 6'd0) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_colour  <= i_rd_data;
               r_led     <= colour_onehot(i_rd_data);
               r_tone_en <= 1'b1;
               r_state   <= S_ON;
            end
            S_ON: begin
               if (w_expired) begin
                  r_led     <= 4'd0;
                  r_tone_en <= 1'b0;
                  r_state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_expired) begin
                  if (w_last) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_index   <= r_index + 5'd1;
                     r_rd_addr <= r_index + 5'd1;
                     r_state   <= S_FETCH;
                  end
               end
            end
            S_FINISH: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_rd_addr  = r_rd_addr;
   assign o_led      = r_led;
   assign o_tone_en  = r_tone_en;
   assign o_tone_sel = r_colour;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter ON_TICKS, 8, TICK pulses an entry is lit (legal 2..255).
REQ-002 Parameter GAP_TICKS, 4, TICK pulses of dark gap after each entry (legal 1..255).
REQ-003 Parameter MIN_ON_TICKS, 2, floor for on-time when speed-up is enabled (legal 1..ON_TICKS).
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 START  in  1  one-cycle request to play entries 0..LEN-1.
REQ-007 ABORT  in  1  stop playback immediately.
REQ-008 LEN  in  6  number of entries to play, 0..32; sampled on accepted START.
REQ-009 TICK  in  1  timebase pulse, one cycle wide.
REQ-010 RD_ADDR  out  5  pattern-memory read address.
REQ-011 RD_DATA  in  2  colour code, valid the cycle after RD_ADDR is presented.
REQ-012 LED  out  4  one-hot lamp drive, bit n lit for colour n.
REQ-013 TONE_EN  out  1  tone enable, high exactly when LED is non-zero.
REQ-014 TONE_SEL  out  2  colour whose tone plays; equals latched colour.
REQ-015 BUSY  out  1  high from accepted START until DONE or abort.
REQ-016 DONE  out  1  one-cycle pulse on normal completion.

Function
REQ-017 States SHALL be IDLE, FETCH, LATCH, ON, GAP, FINISH.
REQ-018 IDLE: START accepted -> FETCH, index 0, LEN captured, BUSY high next cycle; if LEN==0 -> FINISH instead.
REQ-019 FETCH: RD_ADDR=index for one cycle -> LATCH.
REQ-020 LATCH: RD_DATA captured into colour register -> ON; RD_ADDR held at index.
REQ-021 ON: LED=one-hot(colour), TONE_EN=1; dwell counter cleared on entry, increments per TICK; on the TICK making count==on_time -> GAP.
REQ-022 GAP: LED=0, TONE_EN=0; after GAP_TICKS TICK pulses: index==LEN-1 -> FINISH, else index+1 -> FETCH.
REQ-023 FINISH: DONE=1 and BUSY=0 in this cycle -> IDLE.
REQ-024 START while BUSY SHALL be ignored; LEN changes while BUSY SHALL be ignored.
REQ-025 ABORT in any non-IDLE state SHALL force IDLE next cycle, LED=0, TONE_EN=0, BUSY=0, no DONE; ABORT wins over simultaneous START or TICK.
REQ-026 TICK in FETCH, LATCH or FINISH SHALL be ignored (not counted).
REQ-027 LEN values above 32 SHALL be clamped to 32; index SHALL never wrap past 31.
REQ-028 Dwell counter 8 bits, saturates, never wraps.

Reset
REQ-029 On RST: state IDLE, index 0, colour 0, counter 0, RD_ADDR 0, LED 0, TONE_EN 0, TONE_SEL 0, BUSY 0, DONE 0.
REQ-030 RST mid-playback SHALL take effect without a clock edge; no DONE afterward.

Configuration
REQ-031 Macro SEQ_SPEEDUP_EN defined: on_time = ON_TICKS - (index/4), floored at MIN_ON_TICKS.
REQ-032 Macro SEQ_SPEEDUP_EN undefined: on_time = ON_TICKS for every entry; MIN_ON_TICKS unused.

Structure
REQ-033 Shared package seq_pkg SHALL hold state encoding, colour-to-one-hot function, and ON/GAP/MIN default constants.
REQ-034 Dwell counting SHALL be a sub-module dwell_timer (clear, TICK, target in; expired out).

Verification
REQ-035 LEN=3, memory {2,0,3}, TICK every 4 clocks -> LED 0100, 0001, 1000 each lit 8 TICKs, gaps 4 TICKs, DONE one pulse, BUSY falls with DONE.
REQ-036 LEN=0 START -> DONE pulse 2 cycles after START, LED never non-zero.
REQ-037 ABORT during second ON of LEN=5 -> next cycle LED=0, BUSY=0, no DONE; new START then plays from entry 0.
REQ-038 START pulsed during ON with LEN=1 changing to 9 -> ignored; playback completes with original LEN.
REQ-039 SEQ_SPEEDUP_EN, LEN=32, ON_TICKS=8 -> entries 0-3 lit 8 TICKs, 4-7 lit 7, 24-31 lit 2; RD_ADDR reaches 31, no wrap.
REQ-040 RST asserted mid-GAP -> outputs zero immediately; TICK after release leaves LED=0.
